// File: rtl/fpu_pkg.sv
// Shared constants and types for the half-precision FPU register file.
package fpu_pkg;
  localparam int FPLEN_DEF = 16;
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0]    fpr_addr_t;
  typedef logic [FPLEN_DEF-1:0] fpr_data_t;
endpackage

// File: rtl/fpu_scoreboard.sv
// Busy-bit scoreboard for long-latency FPU results: tracks pending destinations
// and reports the hazard conditions that feed the sticky error flag.
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_iss_valid,
  input  logic [AW-1:0] i_iss_waddr,
  input  logic          i_wen1,
  input  logic [AW-1:0] i_waddr1,
  input  logic          i_wen0,
  input  logic [AW-1:0] i_waddr0,
  output logic [DEPTH-1:0] o_busy,
  output logic [AW:0]   o_pend_cnt,
  output logic          o_sb_full,
  output logic          o_err_iss_busy,
  output logic          o_err_wen1_idle,
  output logic          o_err_wen0_busy
);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [AW:0]      r_pend_cnt;
  logic             w_same;
  logic             w_inc;
  logic             w_dec;

  // An issue and a retire to the same register in one cycle keep the bit set.
  assign w_same = i_iss_valid && i_wen1 && (i_iss_waddr == i_waddr1);
  assign w_inc  = i_iss_valid && !r_busy[i_iss_waddr];
  assign w_dec  = i_wen1 && r_busy[i_waddr1] && !w_same;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign w_busy_next[gi] = (i_iss_valid && (i_iss_waddr == AW'(gi))) ? 1'b1 :
                               (i_wen1 && (i_waddr1 == AW'(gi)))        ? 1'b0 :
                               r_busy[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_inc && !w_dec)
        r_pend_cnt <= r_pend_cnt + CNT_ONE;
      else if (!w_inc && w_dec)
        r_pend_cnt <= r_pend_cnt - CNT_ONE;
    end
  end

  assign o_busy          = r_busy;
  assign o_pend_cnt      = r_pend_cnt;
  assign o_sb_full       = (r_pend_cnt == CNT_FULL);
  assign o_err_iss_busy  = i_iss_valid && r_busy[i_iss_waddr];
  assign o_err_wen1_idle = i_wen1 && !r_busy[i_waddr1];
  assign o_err_wen0_busy = i_wen0 && r_busy[i_waddr0];
endmodule

// File: rtl/fpu_fpr_file_sb.sv
// Parametrised FP register file: two write ports, NRD combinational read ports
// with optional write-to-read bypass, and a busy scoreboard for long ops.
module fpu_fpr_file_sb
  import fpu_pkg::*;
#(
  parameter int FPLEN  = FPLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NRD    = 3,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rden,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*FPLEN-1:0] rd,
  output logic [NRD-1:0]       rbusy,
  input  logic                 wen0,
  input  logic [AW-1:0]        waddr0,
  input  logic [FPLEN-1:0]     wd0,
  input  logic                 wen1,
  input  logic [AW-1:0]        waddr1,
  input  logic [FPLEN-1:0]     wd1,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_waddr,
  output logic                 sb_full,
  output logic [AW:0]          pend_cnt,
  output logic                 err_waw
);
  logic [FPLEN-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_err_iss_busy;
  logic             w_err_wen1_idle;
  logic             w_err_wen0_busy;
  logic             w_collide;
  logic             r_err_waw;

  fpu_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sb (
    .clk             (clk),
    .rst             (rst),
    .i_iss_valid     (iss_valid),
    .i_iss_waddr     (iss_waddr),
    .i_wen1          (wen1),
    .i_waddr1        (waddr1),
    .i_wen0          (wen0),
    .i_waddr0        (waddr0),
    .o_busy          (w_busy),
    .o_pend_cnt      (pend_cnt),
    .o_sb_full       (sb_full),
    .o_err_iss_busy  (w_err_iss_busy),
    .o_err_wen1_idle (w_err_wen1_idle),
    .o_err_wen0_busy (w_err_wen0_busy)
  );

  assign w_collide = wen0 && wen1 && (waddr0 == waddr1);

  // Port 1 is written last so a same-address collision keeps the long-op result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        r_regs[k] <= '0;
    end else begin
      if (wen0)
        r_regs[waddr0] <= wd0;
      if (wen1)
        r_regs[waddr1] <= wd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err_waw <= 1'b0;
    else if (w_collide || w_err_iss_busy || w_err_wen1_idle || w_err_wen0_busy)
      r_err_waw <= 1'b1;
  end

  assign err_waw = r_err_waw;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]    w_a;
      logic [FPLEN-1:0] w_d;
      logic             w_b;

      assign w_a = raddr[gi*AW +: AW];

      always_comb begin
        w_d = '0;
        w_b = 1'b0;
        if (!rst && rden[gi]) begin
          w_d = r_regs[w_a];
          w_b = w_busy[w_a];
          // A forwarded long-op result is exactly the write that retires the busy bit.
          if (BYPASS != 0) begin
            if (wen1 && (waddr1 == w_a)) begin
              w_d = wd1;
              w_b = 1'b0;
            end else if (wen0 && (waddr0 == w_a)) begin
              w_d = wd0;
            end
          end
        end
      end

      assign rd[gi*FPLEN +: FPLEN] = w_d;
      assign rbusy[gi]             = w_b;
    end
  endgenerate
endmodule

// File: tb/tb_fpu_fpr_file_sb.sv
// Self-checking bench for fpu_fpr_file_sb: table-driven vectors through a
// scoreboard queue, plus directed sequences for fill/overflow and async reset.
module tb_fpu_fpr_file_sb;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rden;
  logic [14:0] raddr;
  logic [47:0] rd, rd_nb;
  logic [2:0]  rbusy, rbusy_nb;
  logic        wen0, wen1, iss_valid;
  logic [4:0]  waddr0, waddr1, iss_waddr;
  logic [15:0] wd0, wd1;
  logic        sb_full, sb_full_nb, err_waw, err_nb;
  logic [5:0]  pend_cnt, pend_nb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_fpr_file_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rd(rd), .rbusy(rbusy),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0), .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .sb_full(sb_full), .pend_cnt(pend_cnt), .err_waw(err_waw)
  );

  fpu_fpr_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rd(rd_nb), .rbusy(rbusy_nb),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0), .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .sb_full(sb_full_nb), .pend_cnt(pend_nb), .err_waw(err_nb)
  );

  typedef struct {
    logic [2:0]  rden;
    fpr_addr_t   ra0, ra1;
    logic        wen0;
    fpr_addr_t   wa0;
    fpr_data_t   wd0;
    logic        wen1;
    fpr_addr_t   wa1;
    fpr_data_t   wd1;
    logic        iss;
    fpr_addr_t   ia;
    fpr_data_t   e_rd0;
    logic        e_rb0;
    fpr_data_t   e_rd1;
    fpr_data_t   e_nb_rd0;
    logic        e_nb_rb0;
    logic [5:0]  e_pend;
    logic        e_err;
  } vec_t;

  vec_t vecs [14];
  vec_t exp_q [$];
  vec_t cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic idle();
    rden = '0; raddr = '0;
    wen0 = 1'b0; waddr0 = '0; wd0 = '0;
    wen1 = 1'b0; waddr1 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_waddr = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    //          rden    ra0 ra1 wen0 wa0 wd0       wen1 wa1 wd1       iss ia  e_rd0    rb0  e_rd1    nb_rd0   nbrb pend err
    vecs[0]  = '{3'b001, 5, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0};
    vecs[1]  = '{3'b111, 3, 5, 1, 3, 16'h3C00, 0, 0, 16'h0000, 0, 0, 16'h3C00, 0, 16'h0000, 16'h0000, 0, 0, 0};
    vecs[2]  = '{3'b001, 3, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h3C00, 0, 16'h0000, 16'h3C00, 0, 0, 0};
    vecs[3]  = '{3'b001, 7, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0};
    vecs[4]  = '{3'b001, 7, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 1, 1, 0};
    vecs[5]  = '{3'b001, 7, 0, 0, 0, 16'h0000, 1, 7, 16'h4200, 0, 0, 16'h4200, 0, 16'h0000, 16'h0000, 1, 0, 0};
    vecs[6]  = '{3'b001, 7, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h4200, 0, 16'h0000, 16'h4200, 0, 0, 0};
    vecs[7]  = '{3'b000, 7, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0};
    vecs[8]  = '{3'b111, 9, 9, 1, 9, 16'h1111, 1, 9, 16'h2222, 0, 0, 16'h2222, 0, 16'h2222, 16'h0000, 0, 0, 1};
    vecs[9]  = '{3'b001, 9, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h2222, 0, 16'h0000, 16'h2222, 0, 0, 1};
    vecs[10] = '{3'b001, 4, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 4, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 1};
    vecs[11] = '{3'b001, 4, 0, 0, 0, 16'h0000, 1, 4, 16'h0ABC, 1, 4, 16'h0ABC, 0, 16'h0000, 16'h0000, 1, 1, 1};
    vecs[12] = '{3'b001, 4, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0ABC, 1, 16'h0000, 16'h0ABC, 1, 1, 1};
    vecs[13] = '{3'b010, 0, 4, 1, 4, 16'h5555, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h5555, 16'h0000, 0, 1, 1};

    idle();
    rst = 1'b1;
    rden = 3'b111;
    raddr = {5'd2, 5'd1, 5'd0};
    #2;
    chk("reset_rd", {16'h0, rd}, 64'h0);
    chk("reset_rbusy", {61'h0, rbusy}, 64'h0);
    chk("reset_rd_nb", {16'h0, rd_nb}, 64'h0);
    chk("reset_rbusy_nb", {61'h0, rbusy_nb}, 64'h0);
    chk("reset_pend", {58'h0, pend_cnt}, 64'h0);
    chk("reset_err", {63'h0, err_waw}, 64'h0);
    chk("reset_full", {63'h0, sb_full}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rden = vecs[i].rden;
      raddr = {vecs[i].ra1, vecs[i].ra1, vecs[i].ra0};
      wen0 = vecs[i].wen0; waddr0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      wen1 = vecs[i].wen1; waddr1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      iss_valid = vecs[i].iss; iss_waddr = vecs[i].ia;
      exp_q.push_back(vecs[i]);
      #2;
      cur = exp_q.pop_front();
      chk($sformatf("v%0d_rd0", i), {48'h0, rd[15:0]}, {48'h0, cur.e_rd0});
      chk($sformatf("v%0d_rbusy0", i), {63'h0, rbusy[0]}, {63'h0, cur.e_rb0});
      chk($sformatf("v%0d_rd1", i), {48'h0, rd[31:16]}, {48'h0, cur.e_rd1});
      chk($sformatf("v%0d_rd2", i), {48'h0, rd[47:32]},
          {48'h0, (cur.rden[2] ? cur.e_rd1 : 16'h0000)});
      chk($sformatf("v%0d_nb_rd0", i), {48'h0, rd_nb[15:0]}, {48'h0, cur.e_nb_rd0});
      chk($sformatf("v%0d_nb_rbusy0", i), {63'h0, rbusy_nb[0]}, {63'h0, cur.e_nb_rb0});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pend", i), {58'h0, pend_cnt}, {58'h0, cur.e_pend});
      chk($sformatf("v%0d_err", i), {63'h0, err_waw}, {63'h0, cur.e_err});
      chk($sformatf("v%0d_full", i), {63'h0, sb_full}, 64'h0);
      $display("[TB] vec %0d rden=%b ra0=%0d rd0=%h rbusy0=%b pend=%0d err=%b",
               i, cur.rden, cur.ra0, rd[15:0], rbusy[0], pend_cnt, err_waw);
    end

    // Fill every register, then issue once more.
    idle();
    pulse_reset();
    chk("fill_start_pend", {58'h0, pend_cnt}, 64'h0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      iss_valid = 1'b1;
      iss_waddr = 5'(k);
      @(posedge clk);
      #1;
      chk($sformatf("fill%0d_pend", k), {58'h0, pend_cnt}, 64'(k + 1));
      chk($sformatf("fill%0d_full", k), {63'h0, sb_full}, {63'h0, (k == 31)});
    end
    chk("fill_err", {63'h0, err_waw}, 64'h0);
    @(negedge clk);
    iss_valid = 1'b1;
    iss_waddr = 5'd0;
    @(posedge clk);
    #1;
    chk("over_pend", {58'h0, pend_cnt}, 64'd32);
    chk("over_full", {63'h0, sb_full}, 64'h1);
    chk("over_err", {63'h0, err_waw}, 64'h1);
    chk("over_nb_pend", {58'h0, pend_nb}, 64'd32);
    chk("over_nb_full", {63'h0, sb_full_nb}, 64'h1);
    chk("over_nb_err", {63'h0, err_nb}, 64'h1);
    $display("[TB] fill pend=%0d sb_full=%b err=%b", pend_cnt, sb_full, err_waw);

    // Five pending ops, a short write to a busy register, then async reset mid-cycle.
    idle();
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iss_valid = 1'b1;
      iss_waddr = 5'(k);
    end
    @(negedge clk);
    idle();
    wen0 = 1'b1; waddr0 = 5'd1; wd0 = 16'h1234;
    @(posedge clk);
    #1;
    chk("mid_pend5", {58'h0, pend_cnt}, 64'd5);
    chk("wen0_busy_err", {63'h0, err_waw}, 64'h1);
    @(negedge clk);
    idle();
    rden = 3'b001; raddr = 15'd1;
    #1;
    chk("wen0_busy_rd", {48'h0, rd[15:0]}, 64'h1234);
    chk("wen0_busy_rbusy", {63'h0, rbusy[0]}, 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_pend", {58'h0, pend_cnt}, 64'h0);
    chk("async_rd", {48'h0, rd[15:0]}, 64'h0);
    chk("async_rbusy", {63'h0, rbusy[0]}, 64'h0);
    chk("async_err", {63'h0, err_waw}, 64'h0);
    #1 rst = 1'b0;
    #1;
    chk("async_busy_cleared", {63'h0, rbusy[0]}, 64'h0);
    chk("async_reg_cleared", {48'h0, rd[15:0]}, 64'h0);
    $display("[TB] async reset pend=%0d rd0=%h err=%b", pend_cnt, rd[15:0], err_waw);

    // A late long-latency result after reset is stored and flagged.
    @(negedge clk);
    wen1 = 1'b1; waddr1 = 5'd2; wd1 = 16'h7777;
    rden = 3'b001; raddr = 15'd2;
    #2;
    chk("late_wen1_bypass", {48'h0, rd[15:0]}, 64'h7777);
    @(posedge clk);
    #1;
    chk("late_wen1_err", {63'h0, err_waw}, 64'h1);
    chk("late_wen1_pend", {58'h0, pend_cnt}, 64'h0);
    @(negedge clk);
    wen1 = 1'b0;
    #1;
    chk("late_wen1_stored", {48'h0, rd[15:0]}, 64'h7777);
    $display("[TB] late wen1 rd0=%h err=%b", rd[15:0], err_waw);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_fpr_file_sb.md
Name: fpu_fpr_file_sb

Overview:
- Parametrised FP register file for the half-precision FPU; successor to the single-write-port FPR array.
- Adds configurable width, depth and read-port count.
- Adds a second write port for long-latency results (div/sqrt), optional write-to-read bypass, and a per-register busy scoreboard.
- Sits between decode/issue (reads, scoreboard set) and the FPU writeback stages (writes, scoreboard clear).

Parameters:
- FPLEN, 16, register data width in bits.
- DEPTH, 32, number of registers; power of two, minimum 2.
- NRD, 3, number of read ports.
- BYPASS, 1, 1 = a same-cycle write forwards to matching reads; 0 = reads return the stored value.
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rden  in  NRD  per-port read enable.
- raddr  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rd  out  NRD*FPLEN  read data; port i at [i*FPLEN +: FPLEN].
- rbusy  out  NRD  addressed register has a long-latency write pending.
- wen0  in  1  short-pipe write enable.
- waddr0  in  AW  short-pipe write address.
- wd0  in  FPLEN  short-pipe write data.
- wen1  in  1  long-latency write enable; also clears busy.
- waddr1  in  AW  long-latency write address.
- wd1  in  FPLEN  long-latency write data.
- iss_valid  in  1  long-latency op issued; set busy.
- iss_waddr  in  AW  destination register of the issued op.
- sb_full  out  1  pending count == DEPTH.
- pend_cnt  out  AW+1  number of busy registers.
- err_waw  out  1  sticky hazard/collision flag.

Behaviour:
- Reset (async, rst=1):
  - all registers and busy bits = 0; pend_cnt = 0; err_waw = 0.
  - rd = 0 and rbusy = 0 while rst is asserted.
- Reads are combinational, zero latency:
  - rden[i]=0 -> rd[i]=0 and rbusy[i]=0.
  - rden[i]=1 -> rd[i]=reg[raddr[i]]; rbusy[i]=busy[raddr[i]].
- Bypass (BYPASS=1), checked in this order:
  - wen1 and waddr1==raddr[i] -> rd[i]=wd1 and rbusy[i]=0.
  - else wen0 and waddr0==raddr[i] -> rd[i]=wd0.
  - With BYPASS=0 the new value is visible the cycle after the write.
- Writes take effect at the clock edge.
  - wen0 and wen1 to the same address in one cycle: wd1 is stored and err_waw is set.
- Scoreboard:
  - iss_valid sets busy[iss_waddr] at the edge.
  - wen1 clears busy[waddr1] at the edge.
  - iss_valid and wen1 to the same address in one cycle: set wins (back-to-back reuse); pend_cnt is unchanged.
  - iss_valid to an already-busy register: busy stays 1, pend_cnt unchanged, err_waw set.
  - wen1 to a non-busy register: the data is written, pend_cnt unchanged, err_waw set.
  - wen0 to a busy register: the data is written, busy is unchanged, err_waw set.
- pend_cnt:
  - +1 on a set of a previously clear bit; -1 on a clear of a previously set bit; both events in one cycle net to 0.
  - Never wraps; saturates at DEPTH and 0 by construction.
  - sb_full = (pend_cnt == DEPTH).
  - iss_valid while sb_full: busy is already set for every register, so this is the already-busy case (err_waw set).
- err_waw is cleared only by rst.
- No register is hardwired to zero.
- Reset asserted mid-operation clears all pending state immediately; in-flight wen1 results after reset are written normally and flag err_waw.

Decomposition:
- Shared package fpu_pkg:
  - FPLEN default constant.
  - fpr_addr_t typedef (logic [AW-1:0]).
  - fpr_data_t typedef.
- One sub-module: fpu_scoreboard. It holds the busy vector, pend_cnt, sb_full and the err_waw source terms for the scoreboard cases.
- Register array, write merge and read/bypass muxing live in the top module.

Test Plan:
- Reset then read:
  - rst=1 -> rd=0 on all ports.
  - After release, rden=1, raddr=5 -> rd=0, rbusy=0, pend_cnt=0.
- Write with bypass:
  - wen0=1, waddr0=3, wd0=16'h3C00; same cycle rden0=1, raddr0=3.
  - BYPASS=1 -> rd0=16'h3C00 in that cycle; next cycle it reads from storage as 16'h3C00.
  - BYPASS=0 -> rd0=0 in the write cycle, 16'h3C00 in the next.
- Scoreboard round trip:
  - iss_valid, iss_waddr=7 -> next cycle rbusy for raddr=7 is 1, pend_cnt=1.
  - Then wen1, waddr1=7, wd1=16'h4200 -> same-cycle rd=16'h4200 with rbusy=0; next cycle pend_cnt=0.
- Collision:
  - wen0 (wd0=16'h1111) and wen1 (wd1=16'h2222) both to waddr=9 -> reg9=16'h2222, err_waw=1 and stays 1 until rst.
- Simultaneous set/clear and full:
  - iss_valid to 4 and wen1 to 4 while busy[4]=1 -> busy[4] stays 1, pend_cnt unchanged.
  - Issue to all 32 registers -> sb_full=1, pend_cnt=32.
  - One more issue -> err_waw=1, pend_cnt stays 32.
- Async reset mid-flight:
  - With pend_cnt=5, pulse rst between clock edges -> pend_cnt=0, busy all 0, rd=0 immediately, without waiting for a clock edge.
